pipe_stage_skid: RTL

//   Parametrised pipeline stage register: next generation of the fixed EX/MEM-style flop banks.

---
 rtl/pipe_stage_skid.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - pipeline stage register with 2-entry skid buffer, valid/ready handshake and flush
//
// Carries control, data and instruction fields between two pipeline stages.
// The main entry drives out_*; a second (skid) entry absorbs one extra push
// while downstream is stalled, so in_ready can be a registered signal with no
// combinational path from in_valid or out_ready.
//
// Ports:
//   clk        in   1       clock, rising edge
//   rst        in   1       asynchronous reset, active-high
//   in_valid   in   1       upstream presents an entry
//   in_ready   out  1       stage can accept (flop output)
//   in_ctrl    in   CTRL_W  incoming control bits
//   in_data    in   DATA_W  incoming payload
//   in_inst    in   INST_W  incoming instruction
//   flush      in   1       kill all held entries, present a bubble
//   out_valid  out  1       main entry valid
//   out_ready  in   1       downstream accepts
//   out_ctrl   out  CTRL_W  main entry control, 0 in a bubble
//   out_data   out  DATA_W  main entry payload
//   out_inst   out  INST_W  main entry instruction, NOP_INST in a bubble
//   out_nop    out  1       ~out_valid
//   occupancy  out  2       entries held (0..2)

module pipe_stage_skid #(
  parameter int                CTRL_W   = 8,
  parameter int                DATA_W   = 64,
  parameter int                INST_W   = 16,
  parameter logic [INST_W-1:0] NOP_INST = 16'h0800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [INST_W-1:0] in_inst,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [INST_W-1:0] out_inst,
  output logic              out_nop,
  output logic [1:0]        occupancy
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic              in_ready_q;

  logic [CTRL_W-1:0] main_ctrl_q;
  logic [DATA_W-1:0] main_data_q;
  logic [INST_W-1:0] main_inst_q;

  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [INST_W-1:0] skid_inst_q;

  logic push;
  logic pop;

  // Datapath steering decided alongside the next state; at most one of the
  // main-register actions is asserted in any cycle.
  logic load_main_in;
  logic load_main_skid;
  logic clear_main;
  logic load_skid;
  logic clear_skid;

  assign out_valid = (state_q != S_EMPTY);
  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    clear_main     = 1'b0;
    load_skid      = 1'b0;
    clear_skid     = 1'b0;

    if (flush) begin
      // Any same-cycle push is dropped; a same-cycle pop has already been
      // seen downstream, so nothing needs to be preserved.
      state_d    = S_EMPTY;
      clear_main = 1'b1;
      clear_skid = 1'b1;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (push) begin
            state_d      = S_BUSY;
            load_main_in = 1'b1;
          end
        end
        S_BUSY: begin
          if (push && pop) begin
            load_main_in = 1'b1;
          end else if (push) begin
            state_d   = S_FULL;
            load_skid = 1'b1;
          end else if (pop) begin
            state_d    = S_EMPTY;
            clear_main = 1'b1;
          end
        end
        S_FULL: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            state_d        = S_BUSY;
            load_main_skid = 1'b1;
            clear_skid     = 1'b1;
          end
        end
        default: begin
          state_d    = S_EMPTY;
          clear_main = 1'b1;
          clear_skid = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_q  <= 1'b1;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      main_inst_q <= NOP_INST;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_inst_q <= NOP_INST;
    end else begin
      // Registered ready: computed from the next state, never from inputs
      // directly on the output side.
      in_ready_q <= (state_d != S_FULL);

      if (load_main_in) begin
        main_ctrl_q <= in_ctrl;
        main_data_q <= in_data;
        main_inst_q <= in_inst;
      end else if (load_main_skid) begin
        main_ctrl_q <= skid_ctrl_q;
        main_data_q <= skid_data_q;
        main_inst_q <= skid_inst_q;
      end else if (clear_main) begin
        // Bubble: side-effect-free control and a NOP; payload left as is.
        main_ctrl_q <= '0;
        main_inst_q <= NOP_INST;
      end

      if (load_skid) begin
        skid_ctrl_q <= in_ctrl;
        skid_data_q <= in_data;
        skid_inst_q <= in_inst;
      end else if (clear_skid) begin
        skid_ctrl_q <= '0;
        skid_inst_q <= NOP_INST;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign out_inst  = main_inst_q;
  assign out_nop   = ~out_valid;
  assign occupancy = state_q;

endmodule
